// File: rtl/sync_fifo_pkg.sv
// Shared helpers and types for the single-clock FIFO.
package sync_fifo_pkg;

  typedef enum logic {STD, FWFT} rd_mode_e;

  // Pointer/count width: address bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module sync_fifo_mem #(
  parameter int unsigned size  = 8,
  parameter int unsigned depth = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] waddr,
  input  logic [size-1:0]          wdata,
  input  logic [$clog2(depth)-1:0] raddr,
  output logic [size-1:0]          rdata
);

  logic [size-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard/FWFT read, programmable flags, occupancy
// count, sticky overflow/underflow and synchronous flush.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned size  = 8,
  parameter int unsigned depth = 16,
  parameter int unsigned fwft  = 0
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      flush,
  input  logic                      w_en,
  input  logic [size-1:0]           datain,
  input  logic                      r_en,
  output logic [size-1:0]           dataout,
  output logic                      fullN,
  output logic                      emptyN,
  output logic                      afullN,
  output logic                      aemptyN,
  input  logic [ptr_w(depth)-1:0]   af_thresh,
  input  logic [ptr_w(depth)-1:0]   ae_thresh,
  output logic [ptr_w(depth)-1:0]   count,
  output logic                      ovf,
  output logic                      udf
);

  localparam int unsigned CW = ptr_w(depth);
  localparam int unsigned AW = $clog2(depth);
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);
  localparam rd_mode_e MODE = (fwft != 0) ? FWFT : STD;

  logic [CW-1:0]   wptr, rptr;
  logic [size-1:0] head;
  logic [size-1:0] dout_q;
  logic            is_full, is_empty;
  logic            wr_acc, rd_acc;

  assign is_full  = (count == FULL_CNT);
  assign is_empty = (count == '0);
  assign wr_acc   = w_en && !is_full;
  assign rd_acc   = r_en && !is_empty;

  sync_fifo_mem #(
    .size  (size),
    .depth (depth)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && !flush),
    .waddr (wptr[AW-1:0]),
    .wdata (datain),
    .raddr (rptr[AW-1:0]),
    .rdata (head)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      dout_q <= '0;
    end else if (flush) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      dout_q <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + CW'(1);
      if (rd_acc) begin
        rptr   <= rptr + CW'(1);
        dout_q <= head;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A write presented while full is dropped even when a read frees a slot.
      if (w_en && is_full)  ovf <= 1'b1;
      if (r_en && is_empty) udf <= 1'b1;
    end
  end

  always_comb begin
    dataout = dout_q;
    if (MODE == FWFT) dataout = is_empty ? '0 : head;
  end

  assign fullN   = !is_full;
  assign emptyN  = !is_empty;
  assign afullN  = !(count >= af_thresh);
  assign aemptyN = !(count <= ae_thresh);

endmodule

// File: tb/tb_sync_fifo.sv
// Checks standard and FWFT instances side by side against a queue-based model.
module tb_sync_fifo;

  localparam int unsigned SIZE  = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            clr, flush, w_en, r_en;
  logic [SIZE-1:0] datain;
  logic [CW-1:0]   af_thresh, ae_thresh;

  logic [SIZE-1:0] s_dout, f_dout;
  logic            s_fullN, s_emptyN, s_afullN, s_aemptyN, s_ovf, s_udf;
  logic            f_fullN, f_emptyN, f_afullN, f_aemptyN, f_ovf, f_udf;
  logic [CW-1:0]   s_count, f_count;

  int checks = 0;
  int errors = 0;

  int              q[$];
  logic            ovf_m, udf_m;
  logic [SIZE-1:0] dstd_m;

  always #5 clk = ~clk;

  sync_fifo #(.size(SIZE), .depth(DEPTH), .fwft(0)) u_std (
    .clk(clk), .clr(clr), .flush(flush), .w_en(w_en), .datain(datain),
    .r_en(r_en), .dataout(s_dout), .fullN(s_fullN), .emptyN(s_emptyN),
    .afullN(s_afullN), .aemptyN(s_aemptyN), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .count(s_count), .ovf(s_ovf), .udf(s_udf)
  );

  sync_fifo #(.size(SIZE), .depth(DEPTH), .fwft(1)) u_fwft (
    .clk(clk), .clr(clr), .flush(flush), .w_en(w_en), .datain(datain),
    .r_en(r_en), .dataout(f_dout), .fullN(f_fullN), .emptyN(f_emptyN),
    .afullN(f_afullN), .aemptyN(f_aemptyN), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .count(f_count), .ovf(f_ovf), .udf(f_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"},    32'(s_count),  32'(n));
    chk({tag, ".fullN"},    32'(s_fullN),  32'(n != DEPTH));
    chk({tag, ".emptyN"},   32'(s_emptyN), 32'(n != 0));
    chk({tag, ".afullN"},   32'(s_afullN), 32'(!(n >= int'(af_thresh))));
    chk({tag, ".aemptyN"},  32'(s_aemptyN),32'(!(n <= int'(ae_thresh))));
    chk({tag, ".ovf"},      32'(s_ovf),    32'(ovf_m));
    chk({tag, ".udf"},      32'(s_udf),    32'(udf_m));
    chk({tag, ".dout_std"}, 32'(s_dout),   32'(dstd_m));
    chk({tag, ".f_count"},  32'(f_count),  32'(n));
    chk({tag, ".f_emptyN"}, 32'(f_emptyN), 32'(n != 0));
    chk({tag, ".f_ovf"},    32'(f_ovf),    32'(ovf_m));
    chk({tag, ".dout_fwft"},32'(f_dout),   (n != 0) ? 32'(q[0]) : 32'd0);
  endtask

  // One clock edge: update the model from the inputs seen at the edge, then check.
  task automatic step(input string tag);
    @(posedge clk);
    if (flush) begin
      q.delete();
      ovf_m  = 1'b0;
      udf_m  = 1'b0;
      dstd_m = '0;
    end else begin
      bit full, empty;
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (w_en && full)  ovf_m = 1'b1;
      if (r_en && empty) udf_m = 1'b1;
      if (r_en && !empty) dstd_m = SIZE'(q.pop_front());
      if (w_en && !full) q.push_back(int'(datain));
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    clr = 1'b1; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; datain = '0;
    af_thresh = '0; ae_thresh = CW'(3);
    ovf_m = 1'b0; udf_m = 1'b0; dstd_m = '0;
    #3;
    check_all("reset");
    #9;
    clr = 1'b0;
    af_thresh = CW'(12);

    // Fill with 0x00..0x0F; threshold flags are checked every edge.
    for (int i = 0; i < 16; i++) begin
      idle(); w_en = 1'b1; datain = SIZE'(i);
      step("fill");
    end
    chk("full.count", 32'(s_count), 32'd16);

    // Write while full, with and without a concurrent read.
    idle(); w_en = 1'b1; datain = 8'hAA;
    step("ovf");
    chk("ovf.flag", 32'(s_ovf), 32'd1);
    idle(); w_en = 1'b1; r_en = 1'b1; datain = 8'hAB;
    step("ovf_rd");

    for (int i = 0; i < 15; i++) begin
      idle(); r_en = 1'b1;
      step("drain");
    end
    chk("drain.emptyN", 32'(s_emptyN), 32'd0);

    idle(); r_en = 1'b1;
    step("udf");
    chk("udf.flag", 32'(s_udf), 32'd1);

    idle(); flush = 1'b1;
    step("flush");
    chk("flush.ovf", 32'(s_ovf), 32'd0);

    // Simultaneous read/write at count 5.
    for (int i = 0; i < 5; i++) begin
      idle(); w_en = 1'b1; datain = SIZE'(8'h30 + i);
      step("pre5");
    end
    for (int i = 0; i < 3; i++) begin
      idle(); w_en = 1'b1; r_en = 1'b1; datain = SIZE'(8'h40 + i);
      step("rw5");
    end
    chk("rw5.count", 32'(s_count), 32'd5);
    for (int i = 0; i < 5; i++) begin
      idle(); r_en = 1'b1;
      step("post5");
    end

    // FWFT single-word visibility and pop; flush takes priority over w_en.
    idle(); flush = 1'b1; w_en = 1'b1; datain = 8'h11;
    step("flush_pri");
    idle(); w_en = 1'b1; datain = 8'h5C;
    step("fwft_wr");
    chk("fwft.dout", 32'(f_dout), 32'h5C);
    idle(); r_en = 1'b1;
    step("fwft_pop");
    chk("fwft.empty_dout", 32'(f_dout), 32'h0);

    // Asynchronous clear at count 9, between edges.
    for (int i = 0; i < 9; i++) begin
      idle(); w_en = 1'b1; datain = SIZE'(8'h80 + i);
      step("pre_clr");
    end
    idle();
    #2;
    clr = 1'b1;
    #1;
    q.delete(); ovf_m = 1'b0; udf_m = 1'b0; dstd_m = '0;
    check_all("clr");
    clr = 1'b0;
    idle(); w_en = 1'b1; datain = 8'h77;
    step("clr_wr");
    idle(); r_en = 1'b1;
    step("clr_rd");
    chk("clr.new_data", 32'(s_dout), 32'h77);

    // Threshold above depth keeps afullN high.
    af_thresh = CW'(17);
    for (int i = 0; i < 17; i++) begin
      idle(); w_en = 1'b1; datain = SIZE'($urandom);
      step("af17");
    end

    // Randomized traffic with varying bias, thresholds and occasional flush.
    for (int i = 0; i < 600; i++) begin
      int unsigned wp, rp;
      wp = (i / 100) % 2 == 0 ? 70 : 35;
      rp = 100 - wp;
      if (i % 50 == 0) begin
        af_thresh = CW'($urandom_range(0, 18));
        ae_thresh = CW'($urandom_range(0, 18));
      end
      w_en   = ($urandom_range(0, 99) < wp);
      r_en   = ($urandom_range(0, 99) < rp);
      flush  = ($urandom_range(0, 99) < 2);
      datain = SIZE'($urandom);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised successor to the team's asynchronous FIFO, used wherever producer and consumer share one clock. Adds configurable width and depth, a first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty flags, an occupancy count, sticky overflow/underflow error flags and a synchronous flush. The active-low fullN/emptyN flags keep the existing FIFO's polarity, so current drivers and monitors reuse unchanged.

## Interface
Parameters:
- size, default 8: data width in bits.
- depth, default 16: number of entries; power of 2, at least 4.
- fwft, default 0: 0 selects standard registered read, 1 selects first-word-fall-through.

Ports:
- clk  in  1  the single clock.
- clr  in  1  reset, asynchronous and active-high.
- flush  in  1  synchronous empty request.
- w_en  in  1  write request.
- datain  in  size  write data.
- r_en  in  1  read request; in FWFT mode, a pop request.
- dataout  out  size  read data.
- fullN  out  1  low when count == depth.
- emptyN  out  1  low when count == 0.
- afullN  out  1  low when count >= af_thresh.
- aemptyN  out  1  low when count <= ae_thresh.
- af_thresh  in  CW  almost-full threshold, with CW = $clog2(depth)+1.
- ae_thresh  in  CW  almost-empty threshold.
- count  out  CW  current occupancy, 0..depth.
- ovf  out  1  sticky overflow flag.
- udf  out  1  sticky underflow flag.

## Operation
- Write acceptance: a write is accepted when w_en=1 and count<depth. The flag state is evaluated before the edge.
- Read acceptance: a read is accepted when r_en=1 and count>0.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
- Write while full: rejected even if a read is accepted in the same cycle. Data is dropped, ovf is set, and the rejected write does not change count.
- Read while empty: no effect on pointers or count; udf is set.
- Pointers: CW bits wide (one extra wrap bit), wrapping modulo 2*depth. Addresses are the low $clog2(depth) bits.
- Flags are decoded combinationally from the count register only; they never depend on w_en or r_en.
- Standard mode (fwft=0): dataout is registered and loads the head word on the edge that accepts a read. It holds its value otherwise, including when empty.
- FWFT mode (fwft=1): dataout equals the head word whenever emptyN=1, and 0 when empty. An accepted r_en advances dataout to the next word.
- flush=1: on the next edge, pointers, count, ovf and udf are cleared, and dataout becomes 0 in standard mode. Flush takes priority over w_en and r_en in the same cycle. Memory contents are not cleared.
- clr=1 at any time, including mid-burst: immediate clear of the pointers, count, ovf, udf and the dataout register. The memory array is not reset.

## Timing
- Reset values: count=0, emptyN=0, fullN=1, aemptyN=0, ovf=0, udf=0, dataout=0. afullN=1, or 0 if af_thresh==0.
- Write latency: a word written at edge k makes emptyN=1 from cycle k+1. In FWFT mode that word is on dataout in cycle k+1.
- Standard read latency: r_en sampled at edge k puts data on dataout after edge k, i.e. 1 cycle.
- FWFT read: zero-latency view of the head; the pop takes effect at the edge.
- ovf/udf rise in the cycle after the offending edge and stay high until clr or flush.
- Thresholds are sampled combinationally. A threshold greater than depth leaves afullN permanently 1.

## Structure
- Package sync_fifo_pkg holds:
  - function ptr_w(depth) returning $clog2(depth)+1;
  - typedef enum {STD, FWFT} rd_mode_e, with the fwft parameter mapped onto it.
- One sub-module, sync_fifo_mem: a simple dual-port array of depth x size with a synchronous write and an asynchronous read address port, and no reset.
- Pointer, count, flag and error logic live in sync_fifo. Expected size is about 200 lines of RTL in total.

## Test plan
Scenarios use size=8 and depth=16.
- Fill and drain: write 16 words 0x00..0x0F. Required: fullN=0 and count=16 after the 16th edge. Then read 16 words. Required: dataout sequence 0x00..0x0F, and emptyN=0 after the last read.
- Overflow: from full, pulse w_en with datain=0xAA. Required: ovf=1 and count=16, and 0xAA is never read out. Then flush. Required: ovf=0 and count=0.
- Underflow and simultaneous access: r_en on empty gives udf=1 and count=0. At count=5, assert w_en and r_en together for 3 cycles. Required: count stays 5 and read order is preserved.
- Thresholds: af_thresh=12, ae_thresh=3. Required: aemptyN goes 0→1 when count goes 3→4, and afullN goes 1→0 when count goes 11→12.
- FWFT (fwft=1): a single write of 0x5C at edge k gives dataout=0x5C and emptyN=1 in cycle k+1. After the r_en pop: dataout=0 and emptyN=0.
- Reset mid-operation: assert clr asynchronously at count=9 between edges. Required: count=0, emptyN=0 and dataout=0 immediately. The next write/read pair returns the new data, not stale words.
